// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
//   Takes an unsigned binary value over a valid/ready handshake. The value is
//   converted to BCD serially with double-dabble, one bit per cycle. One shared
//   BCD-to-seven-segment decoder then fills a shadow register per digit, and a
//   single COMMIT cycle copies every shadow digit to the display at once. The
//   display never shows a partially updated value.
//
//   Optional build macro: SEG7_LAMP_TEST_EN adds the lamp_test input. While it
//   is high, every segment is forced on.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   load_valid  requester presents load_value / blank_lz
//   load_ready  block is idle and accepts a value this cycle
//   load_value  unsigned binary value to display
//   blank_lz    leading-zero blanking enable, captured at the handshake
//   lamp_test   (SEG7_LAMP_TEST_EN only) force every segment lit
//   hex         digit d on hex[7d+6:7d], bit6=g .. bit0=a, active-low
//   busy        conversion / decode / commit in progress
//   overflow    last accepted value exceeded 10^NUM_DIGITS-1
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a handshake, load_ready high
// CONVERT | double-dabble, BIN_W cycles, one binary bit per cycle
// DECODE  | NUM_DIGITS cycles, one digit through the shared decoder
// COMMIT  | shadow registers copied to hex in one cycle
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_W      = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [BIN_W-1:0]        load_value,
    input  logic                    blank_lz,
`ifdef SEG7_LAMP_TEST_EN
    input  logic                    lamp_test,
`endif
    output logic [NUM_DIGITS*7-1:0] hex,
    output logic                    busy,
    output logic                    overflow
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int              BCD_W    = 4 * NUM_DIGITS;
    localparam int              CW       = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int              DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(pow10(NUM_DIGITS) - 64'd1);
    localparam logic [CW-1:0]   BIT_LAST = CW'(BIN_W - 1);
    localparam logic [DW-1:0]   DIG_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]      SEG_BLANK = 7'b1111111;
    localparam logic [6:0]      SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DECODE, S_COMMIT} state_t;

    state_t                          state, state_nxt;
    logic [BIN_W-1:0]                bin_sr;
    logic [BCD_W-1:0]                bcd, bcd_adj;
    logic [CW-1:0]                   bit_cnt;
    logic [DW-1:0]                   dig_cnt;
    logic                            blank_r;
    logic                            ovf_r;
    logic [NUM_DIGITS-1:0][6:0]      shadow;
    logic [NUM_DIGITS*7-1:0]         hex_r;
    logic                            xfer;
    logic                            val_ovf;
    logic [3:0]                      nib_sel;
    logic                            upper_zero;
    logic [6:0]                      seg_sel;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign xfer    = load_valid && load_ready;
    assign val_ovf = (load_value > MAX_VAL);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (load_valid) state_nxt = val_ovf ? S_DECODE : S_CONVERT;
            S_CONVERT: if (bit_cnt == BIT_LAST) state_nxt = S_DECODE;
            S_DECODE:  if (dig_cnt == DIG_LAST) state_nxt = S_COMMIT;
            S_COMMIT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        load_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
    end

    // Double-dabble correction step. Each nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // Shared decoder. A digit is a leading zero when it and every digit
    // above it are zero. Digit 0 is exempt, so a value of 0 still shows "0".
    always_comb begin
        nib_sel    = bcd[{dig_cnt, 2'b00} +: 4];
        upper_zero = ((bcd >> {dig_cnt, 2'b00}) == '0);
        if (ovf_r)
            seg_sel = SEG_DASH;
        else if (blank_r && (dig_cnt != '0) && upper_zero)
            seg_sel = SEG_BLANK;
        else
            seg_sel = bcd_to_seg(nib_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr  <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            dig_cnt <= '0;
            blank_r <= 1'b0;
            ovf_r   <= 1'b0;
            shadow  <= '1;
            hex_r   <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        bin_sr  <= load_value;
                        bcd     <= '0;
                        blank_r <= blank_lz;
                        ovf_r   <= val_ovf;
                        bit_cnt <= '0;
                        dig_cnt <= '0;
                    end
                end
                S_CONVERT: begin
                    bcd     <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + CW'(1);
                end
                S_DECODE: begin
                    shadow[dig_cnt] <= seg_sel;
                    dig_cnt         <= dig_cnt + DW'(1);
                end
                S_COMMIT: hex_r <= shadow;
                default: ;
            endcase
        end
    end

    assign overflow = ovf_r;

`ifdef SEG7_LAMP_TEST_EN
    assign hex = lamp_test ? '0 : hex_r;
`else
    assign hex = hex_r;
`endif

endmodule

// File: tb/tb_seg7_display_ctrl.sv
module tb_seg7_display_ctrl;

    localparam int ND       = 6;
    localparam int BW       = 20;
    localparam int HW       = ND * 7;
    localparam int LAT_NORM = BW + ND + 1;
    localparam int LAT_OVF  = ND + 1;
    localparam int unsigned MAXV = 999999;

    localparam logic [HW-1:0] LIT_123456 = {7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010};
    localparam logic [HW-1:0] LIT_42B    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b0011001, 7'b0100100};
    localparam logic [HW-1:0] LIT_0B     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    localparam logic [HW-1:0] LIT_DASH   = {6{7'b0111111}};
    localparam logic [HW-1:0] LIT_7      = {7'b1000000, 7'b1000000, 7'b1000000,
                                            7'b1000000, 7'b1000000, 7'b1111000};

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          load_valid = 1'b0;
    logic          blank_lz   = 1'b0;
    logic [BW-1:0] load_value = '0;
    logic [HW-1:0] hex;
    logic          load_ready, busy, overflow;
`ifdef SEG7_LAMP_TEST_EN
    logic          lamp_test  = 1'b0;
`endif

    seg7_display_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .blank_lz   (blank_lz),
`ifdef SEG7_LAMP_TEST_EN
        .lamp_test  (lamp_test),
`endif
        .hex        (hex),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Display a value should produce, from decimal arithmetic.
    function automatic logic [HW-1:0] expect_hex(input int unsigned v, input bit blz);
        logic [HW-1:0] r;
        int unsigned   p;
        r = '1;
        p = 1;
        for (int d = 0; d < ND; d++) begin
            if (v > MAXV)                     r[7*d +: 7] = 7'b0111111;
            else if (blz && d > 0 && v < p)   r[7*d +: 7] = 7'h7F;
            else                              r[7*d +: 7] = seg_pat[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Transaction-level model: pending display appears a fixed latency after accept.
    logic [HW-1:0] m_hex  = '1;
    logic [HW-1:0] m_pend = '1;
    bit            m_ovf  = 1'b0;
    int            m_left = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hex  = '1;
            m_ovf  = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_hex = m_pend;
        end else if (load_valid) begin
            m_pend = expect_hex(load_value, blank_lz);
            m_ovf  = (load_value > MAXV);
            m_left = m_ovf ? LAT_OVF : LAT_NORM;
        end
    end

    always @(negedge clk) begin
        logic [HW-1:0] eh;
        eh = m_hex;
`ifdef SEG7_LAMP_TEST_EN
        if (lamp_test) eh = '0;
`endif
        chk("hex_vs_model", hex, eh);
        chk("overflow_vs_model", overflow, m_ovf);
        chk("load_ready_vs_model", load_ready, (m_left == 0));
        chk("busy_vs_model", busy, (m_left != 0));
    end

    // Called #1 after a rising edge with the block idle. Returns #1 after the transfer edge.
    task automatic do_load(input int unsigned v, input bit blz);
        chk("ready_before_load", load_ready, 1'b1);
        #1;
        load_value = BW'(v);
        blank_lz   = blz;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!load_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, exp_lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_hex", hex, {HW{1'b1}});
        chk("reset_ready", load_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overflow", overflow, 1'b0);

        chk("model_123456", expect_hex(123456, 1'b0), LIT_123456);
        chk("model_42_blz", expect_hex(42, 1'b1), LIT_42B);
        chk("model_0_blz", expect_hex(0, 1'b1), LIT_0B);
        chk("model_ovf", expect_hex(1000000, 1'b0), LIT_DASH);
        chk("model_7", expect_hex(7, 1'b0), LIT_7);

        do_load(123456, 1'b0);
        chk("busy_after_load", busy, 1'b1);
        wait_done("lat_123456", LAT_NORM);
        chk("hex_123456", hex, LIT_123456);
        chk("ovf_123456", overflow, 1'b0);

        do_load(42, 1'b1);
        wait_done("lat_42", LAT_NORM);
        chk("hex_42_blz", hex, LIT_42B);

        do_load(0, 1'b1);
        wait_done("lat_0", LAT_NORM);
        chk("hex_0_blz", hex, LIT_0B);

        do_load(1000000, 1'b0);
        chk("ovf_at_handshake", overflow, 1'b1);
        chk("hex_held_during_ovf", hex, LIT_0B);
        wait_done("lat_ovf", LAT_OVF);
        chk("hex_dash", hex, LIT_DASH);

        do_load(7, 1'b0);
        chk("ovf_cleared", overflow, 1'b0);
        wait_done("lat_7", LAT_NORM);
        chk("hex_7", hex, LIT_7);

        // A load_valid pulse during conversion must be ignored.
        do_load(123456, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        load_value = BW'(999);
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        wait_done("lat_ignored_pulse", LAT_NORM - 5);
        chk("hex_after_ignored", hex, LIT_123456);
        repeat (3) @(posedge clk);
        #1 chk("no_late_accept", busy, 1'b0);

        // Reset in the middle of CONVERT.
        do_load(42, 1'b0);
        repeat (8) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_hex", hex, {HW{1'b1}});
        chk("async_rst_ready", load_ready, 1'b1);
        chk("async_rst_busy", busy, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        do_load(42, 1'b1);
        wait_done("lat_after_reset", LAT_NORM);
        chk("hex_42_after_reset", hex, LIT_42B);

`ifdef SEG7_LAMP_TEST_EN
        do_load(123456, 1'b0);
        repeat (BW + 3) @(posedge clk);
        #1 lamp_test = 1'b1;
        #1 chk("lamp_on", hex, {HW{1'b0}});
        @(posedge clk); #1 lamp_test = 1'b0;
        #1 chk("lamp_off_old", hex, LIT_42B);
        wait_done("lat_lamp", LAT_NORM - BW - 4);
        chk("hex_after_lamp", hex, LIT_123456);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Accepts a binary value over a valid/ready handshake and converts it to BCD serially (double-dabble, one bit per cycle).
- Time-shares one internal BCD-to-seven-segment decoder across NUM_DIGITS digit registers, then drives the HEX display bank.
- Sits between datapath result registers and the board's HEX outputs; segments are active-low.

Parameters:
- NUM_DIGITS, 6, number of seven-segment digits driven (digit 0 = least significant).
- BIN_W, 20, width of load_value; must satisfy 2^BIN_W > 10^NUM_DIGITS - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  requester has a value on load_value.
- load_ready  output  1  block can accept a value this cycle.
- load_value  input  BIN_W  unsigned binary value to display.
- blank_lz  input  1  leading-zero blanking enable; sampled at the handshake.
- hex  output  NUM_DIGITS*7  segment patterns; digit d on hex[7d+6:7d]; bit6=g … bit0=a; 0 = lit.
- busy  output  1  conversion or decode in progress.
- overflow  output  1  last accepted value exceeded 10^NUM_DIGITS - 1.

Behaviour:
- Reset (async, reset_n=0):
  - hex = all 7'b1111111 (blank); load_ready=1; busy=0; overflow=0; FSM=IDLE.
  - Shadow registers and BCD shift register are cleared.
  - Reset mid-operation aborts immediately and blanks the display.
- Handshake:
  - load_ready = (state==IDLE); transfer on the rising edge where load_valid && load_ready.
  - load_value and blank_lz are captured at transfer.
  - load_valid while busy is ignored; the requester holds it until ready.
- FSM states: IDLE, CONVERT, DECODE, COMMIT.
- IDLE -> CONVERT on transfer when load_value <= 10^NUM_DIGITS-1; IDLE -> DECODE on transfer when load_value exceeds it. In the overflow case, the overflow flag is set at the handshake and CONVERT is skipped.
- CONVERT (exactly BIN_W cycles):
  - Each cycle, add 3 to every BCD nibble >= 5, then shift the binary MSB into the BCD register.
  - A bit counter runs 0..BIN_W-1; at BIN_W-1 the FSM moves to DECODE.
- DECODE (exactly NUM_DIGITS cycles):
  - A digit counter runs 0..NUM_DIGITS-1; the selected nibble feeds the single shared decoder.
  - The decoder result is written to shadow[digit].
  - Active-low patterns 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Nibbles 10-15 cannot occur; the decoder emits blank for them.
  - Overflow: every shadow digit = 0111111 (dash).
  - Leading-zero blanking (blank_lz=1, no overflow): a digit above the most significant nonzero digit is written 1111111. Digit 0 is never blanked, so value 0 displays "0".
- COMMIT (1 cycle): all shadow registers copy to hex atomically; FSM -> IDLE.
- hex holds the previous value for the whole operation; no partial update is ever visible.
- overflow updates at handshake and holds until the next handshake.
- busy = (state != IDLE).
- Latency, with handshake at edge k:
  - Normal: hex updates and load_ready rises after edge k+BIN_W+NUM_DIGITS+1 (k+27 at defaults).
  - Overflow: after edge k+NUM_DIGITS+1 (k+7).
- Back-to-back: a new transfer may occur on the first edge at which load_ready=1 after COMMIT.

Optional Feature:
- Macro: SEG7_LAMP_TEST_EN.
- Defined:
  - Adds input lamp_test (1 bit).
  - While lamp_test=1, hex = all 0 (every segment lit), combinationally overriding the registers.
  - The FSM, handshake and registers are unaffected; the committed value reappears when lamp_test drops.
- Undefined: port absent; hex always reflects the committed registers.

Test Plan:
- Release reset_n, hold 5 cycles -> hex=42'h3FFFFFFFFFF, load_ready=1, busy=0, overflow=0.
- load 123456, blank_lz=0 -> busy for 27 cycles; then hex5..0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; overflow=0.
- load 42, blank_lz=1 -> hex0=0100100, hex1=0011001, hex2..hex5=1111111. Then load 0, blank_lz=1 -> hex0=1000000, others blank.
- load 1000000 -> overflow=1 at handshake; 7 cycles later all digits = 0111111; the next load of 7 clears overflow; hex0=1111000 and hex1..hex5 = 1000000 (blank_lz=0).
- Pulse load_valid with value 999 at cycle 5 of a 123456 conversion -> not accepted; hex shows 123456 after COMMIT. Assert reset_n=0 mid-CONVERT -> hex blank, load_ready=1 asynchronously.
- SEG7_LAMP_TEST_EN build: lamp_test=1 during DECODE -> hex=0 immediately; drop lamp_test -> committed value with unchanged latency.
